display_scanner: RTL and testbench

Drives the board's 8-digit multiplexed seven-segment display from the controller's `display_code` bus. It latches one frame of 6-bit digit codes and scans the digits one at a time. Each code is decoded to segment patterns, with a dark guard interval at the start of every digit slot to suppress ghosting. It sits between the controller and the top-level display pins.

---
 rtl/display_pkg.sv | 45 ++++
 rtl/segment_decoder.sv | 29 ++
 rtl/display_scanner.sv | 144 ++++++++++++++
 tb/tb_display_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner.
// Contents: the 6-bit display code type, glyph code constants, segment pattern
// constants and a hex-to-segment helper. Segment bit order is {g,f,e,d,c,b,a};
// the decimal point is added by the decoder as bit 7.
package display_pkg;

  // Bit 5: decimal point, bits [4:0]: glyph.
  typedef logic [5:0] display_code_t;

  localparam int unsigned NumDigits = 8;

  localparam logic [4:0] GLYPH_BLANK      = 5'd16;
  localparam logic [4:0] GLYPH_DASH       = 5'd17;
  localparam logic [4:0] GLYPH_UNDERSCORE = 5'd18;

  localparam logic [6:0] SEG_OFF        = 7'h00;
  localparam logic [6:0] SEG_DASH       = 7'h40;
  localparam logic [6:0] SEG_UNDERSCORE = 7'h08;

  localparam logic [7:0] DIGIT_SEL_NONE = 8'hFF;

  function automatic logic [6:0] hex_segments(input logic [3:0] value);
    logic [6:0] seg;
    unique case (value)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/segment_decoder.sv
// Combinational display-code to segment decoder.
// Ports:
//   code    - 6-bit display code (bit 5 = decimal point, bits [4:0] = glyph)
//   segment - active-high segments {dp,g,f,e,d,c,b,a}
// Glyphs 0-15 are hex digits, 17 is '-', 18 is '_', everything else is blank.
module segment_decoder
  import display_pkg::*;
(
  input  display_code_t code,
  output logic [7:0]    segment
);

  logic [4:0] glyph;
  logic [6:0] glyph_seg;

  always_comb begin
    glyph     = code[4:0];
    glyph_seg = SEG_OFF;
    if (glyph[4] == 1'b0) begin
      glyph_seg = hex_segments(glyph[3:0]);
    end else if (glyph == GLYPH_DASH) begin
      glyph_seg = SEG_DASH;
    end else if (glyph == GLYPH_UNDERSCORE) begin
      glyph_seg = SEG_UNDERSCORE;
    end
    segment = {code[5], glyph_seg};
  end

endmodule

// File: rtl/display_scanner.sv
// Eight-digit multiplexed seven-segment display scanner.
// Latches one frame of digit codes at the start of each frame and scans the
// digits one slot at a time, with a dark guard interval at the start of every
// slot to suppress ghosting. All outputs are registered.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   display_code   - per-digit codes, index 0 is the rightmost digit
//   blink_mask     - digits to blink (only with DISPLAY_SCANNER_BLINK_EN)
//   digit_select   - active-low one-hot digit enable
//   segment        - active-high {dp,g,f,e,d,c,b,a}
//   frame_tick     - one-cycle pulse in the cycle after each shadow load
// Optional feature: define DISPLAY_SCANNER_BLINK_EN to add blinking.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned scan_divider = 1000,
  parameter int unsigned blank_cycles = 16,
  parameter int unsigned blink_frames = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0][5:0] display_code,
`ifdef DISPLAY_SCANNER_BLINK_EN
  input  logic [7:0]      blink_mask,
`endif
  output logic [7:0]      digit_select,
  output logic [7:0]      segment,
  output logic            frame_tick
);

  localparam int unsigned PreW = (scan_divider > 1) ? $clog2(scan_divider) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(scan_divider - 1);
  localparam logic [PreW-1:0] BlankLim = PreW'(blank_cycles);

  logic [PreW-1:0]       prescaler_q, prescaler_d;
  logic [2:0]            index_q, index_d;
  logic [7:0][5:0]       shadow_q, shadow_d;
  logic [7:0]            digit_select_q, digit_select_d;
  logic [7:0]            segment_q, segment_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  load;
  logic                  dark;
  logic [7:0]            dec_seg;

  assign load = (index_q == 3'd0) && (prescaler_q == '0);
  assign dark = prescaler_q < BlankLim;

  segment_decoder u_segment_decoder (
    .code    (shadow_q[index_q]),
    .segment (dec_seg)
  );

  // Scan counters and frame shadow.
  always_comb begin
    prescaler_d = prescaler_q + PreW'(1);
    index_d     = index_q;
    if (prescaler_q == PreMax) begin
      prescaler_d = '0;
      index_d     = index_q + 3'd1;
    end
    shadow_d = shadow_q;
    if (load) begin
      shadow_d = display_code;
    end
  end

`ifdef DISPLAY_SCANNER_BLINK_EN
  localparam int unsigned FrW = (blink_frames > 1) ? $clog2(blink_frames) : 1;
  localparam logic [FrW-1:0] FrMax = FrW'(blink_frames - 1);

  logic [FrW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]     mask_q, mask_d;
  logic           phase_on_q, phase_on_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    mask_d      = mask_q;
    phase_on_d  = phase_on_q;
    if (load) begin
      mask_d = blink_mask;
      if (frame_cnt_q == FrMax) begin
        frame_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FrW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      mask_q      <= '0;
      phase_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      mask_q      <= mask_d;
      phase_on_q  <= phase_on_d;
    end
  end
`endif

  // Output registers: computed from the pre-edge state, so pins lag state by one cycle.
  always_comb begin
    frame_tick_d = load;
    if (dark) begin
      digit_select_d = DIGIT_SEL_NONE;
      segment_d      = 8'h00;
    end else begin
      digit_select_d = ~(8'b1 << index_q);
      segment_d      = dec_seg;
`ifdef DISPLAY_SCANNER_BLINK_EN
      // Blinked digits stay selected but show no segments.
      if (!phase_on_q && mask_q[index_q]) begin
        segment_d = 8'h00;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      index_q        <= 3'd0;
      shadow_q       <= {NumDigits{1'b0, GLYPH_BLANK}};
      digit_select_q <= DIGIT_SEL_NONE;
      segment_q      <= 8'h00;
      frame_tick_q   <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      index_q        <= index_d;
      shadow_q       <= shadow_d;
      digit_select_q <= digit_select_d;
      segment_q      <= segment_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign digit_select = digit_select_q;
  assign segment      = segment_q;
  assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner. A reference model derives the expected
// pins from the elapsed cycle count since reset and pushes them into a queue on
// every clock edge; a monitor pops and compares on the following falling edge.
module tb_display_scanner;

  localparam int unsigned SD    = 10;
  localparam int unsigned BC    = 2;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 8 * SD;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0][5:0] display_code;
`ifdef DISPLAY_SCANNER_BLINK_EN
  logic [7:0]      blink_mask;
`endif
  logic [7:0]      digit_select;
  logic [7:0]      segment;
  logic            frame_tick;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t sbq[$];

  always #5 clock = ~clock;

  display_scanner #(
    .scan_divider (SD),
    .blank_cycles (BC),
    .blink_frames (BF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .display_code (display_code),
`ifdef DISPLAY_SCANNER_BLINK_EN
    .blink_mask   (blink_mask),
`endif
    .digit_select (digit_select),
    .segment      (segment),
    .frame_tick   (frame_tick)
  );

  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [7:0] ref_seg(input logic [5:0] c);
    logic [7:0] s;
    int unsigned g;
    g = int'(c[4:0]);
    if (g < 16)       s = hex_tab[g];
    else if (g == 17) s = 8'h40;
    else if (g == 18) s = 8'h08;
    else              s = 8'h00;
    if (c[5]) s = s | 8'h80;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Reference model: cyc is the number of edges since reset release.
  int unsigned     cyc   = 0;
  int unsigned     loads = 0;
  logic [7:0][5:0] sh_m;
  logic [7:0]      mask_m = 8'h00;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc    = 0;
      loads  = 0;
      sh_m   = {8{6'd16}};
      mask_m = 8'h00;
      sbq.delete();
    end else begin
      int unsigned p;
      int unsigned idx;
      exp_t        e;
      p   = cyc % SD;
      idx = (cyc / SD) % 8;
      e.tick = (cyc % FRAME) == 0;
      if (e.tick) begin
        sh_m = display_code;
`ifdef DISPLAY_SCANNER_BLINK_EN
        mask_m = blink_mask;
`endif
        loads++;
      end
      if (p < BC) begin
        e.sel = 8'hFF;
        e.seg = 8'h00;
      end else begin
        e.sel      = 8'hFF;
        e.sel[idx] = 1'b0;
        e.seg      = ref_seg(sh_m[idx]);
`ifdef DISPLAY_SCANNER_BLINK_EN
        // Phase flips off after every BF-th load and back on after the next BF.
        if (((loads / BF) % 2) == 1 && mask_m[idx]) e.seg = 8'h00;
`endif
      end
      sbq.push_back(e);
      cyc++;
    end
  end

  // Monitor.
  always @(negedge clock) begin
    if (reset) begin
      check("reset_dark", {15'd0, digit_select, segment, frame_tick}, {15'd0, 8'hFF, 8'h00, 1'b0});
    end else if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("digit_select", {24'd0, digit_select}, {24'd0, e.sel});
      check("segment", {24'd0, segment}, {24'd0, e.seg});
      check("frame_tick", {31'd0, frame_tick}, {31'd0, e.tick});
    end
  end

  task automatic wait_phase(input int unsigned m);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((cyc % FRAME) != m && n < 4 * FRAME);
    if ((cyc % FRAME) != m) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: got %0d, required %0d", cyc % FRAME, m);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) display_code[i] = 6'd5;
`ifdef DISPLAY_SCANNER_BLINK_EN
    blink_mask = 8'h01;
`endif
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    repeat (FRAME + 20) @(negedge clock);

    // Codes 0..7 for one full frame and more.
    wait_phase(40);
    for (int i = 0; i < 8; i++) display_code[i] = 6'(i);
    repeat (2 * FRAME) @(negedge clock);

    // Mid-frame change must not tear the current frame.
    wait_phase(40);
    for (int i = 2; i < 8; i++) display_code[i] = 6'd8;
    wait_phase(40);
    for (int i = 2; i < 8; i++) display_code[i] = 6'd17;
    repeat (FRAME + 20) @(negedge clock);

    // Decimal point and blank glyphs.
    display_code[0] = 6'h21;
    display_code[1] = 6'd16;
    display_code[2] = 6'd25;
    display_code[3] = 6'd18;
    repeat (2 * FRAME) @(negedge clock);

    // Random codes, including changes right before a load edge.
    for (int n = 0; n < 12 * FRAME; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 15) == 0) begin
        display_code[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
      end
      if ((cyc % FRAME) == 0 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) display_code[i] = 6'($urandom_range(0, 63));
`ifdef DISPLAY_SCANNER_BLINK_EN
        blink_mask = 8'($urandom_range(0, 255));
`endif
      end
    end

    // Asynchronous reset at prescaler 5 of slot 3.
    wait_phase(3 * SD + 5);
    check("pre_reset_lit", {24'd0, digit_select}, {24'd0, 8'hF7});
    #2 reset = 1'b1;
    #1 check("async_reset_dark", {16'd0, digit_select, segment}, {16'd0, 8'hFF, 8'h00});
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    repeat (FRAME + 20) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
